// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipeline_ctrl_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned FCNT_W     = 3;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencing for the 5-stage core: load-use, EX redirect and
// data-memory wait, plus saturating performance counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_EXTRA = 1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
   input  logic                  id_valid_i,
   input  logic                  ex_memread_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
   input  logic                  ex_valid_i,
   input  logic                  ex_redirect_i,
   input  logic                  dmem_busy_i,
   input  logic                  cnt_clr_i,
   output logic                  pc_stall_o,
   output logic                  ifid_stall_o,
   output logic                  ifid_flush_o,
   output logic                  idex_stall_o,
   output logic                  idex_flush_o,
   output logic                  exmem_stall_o,
   output logic [1:0]            state_o,
   output logic [CNT_W-1:0]      ldu_cnt_o,
   output logic [CNT_W-1:0]      redir_cnt_o,
   output logic [CNT_W-1:0]      memw_cnt_o
);

   localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_EXTRA);
   localparam bit                HAS_EXTRA  = (FLUSH_EXTRA != 0);

   state_e            state_q, state_d, ret_q, ret_d, eff_st;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic              load_use;
   logic              ldu_inc, redir_inc, memw_inc;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_RUN;
         ret_q   <= ST_RUN;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign load_use = ex_memread_i && ex_valid_i && id_valid_i && (ex_rd_addr_i != '0) &&
                     ((ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i));

   // Leaving MEM_WAIT resumes the saved state in the same cycle; 2'd3 decodes as RUN.
   always_comb begin
      eff_st = ST_RUN;
      case (state_q)
         ST_REDIRECT: eff_st = ST_REDIRECT;
         ST_MEM_WAIT: eff_st = ret_q;
         default:     eff_st = ST_RUN;
      endcase
   end

   always_comb begin
      state_d       = ST_RUN;
      ret_d         = ret_q;
      fcnt_d        = fcnt_q;
      pc_stall_o    = 1'b0;
      ifid_stall_o  = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_stall_o  = 1'b0;
      idex_flush_o  = 1'b0;
      exmem_stall_o = 1'b0;
      ldu_inc       = 1'b0;
      redir_inc     = 1'b0;
      memw_inc      = 1'b0;

      if (dmem_busy_i) begin
         pc_stall_o    = 1'b1;
         ifid_stall_o  = 1'b1;
         idex_stall_o  = 1'b1;
         exmem_stall_o = 1'b1;
         memw_inc      = 1'b1;
         state_d       = ST_MEM_WAIT;
         if (state_q != ST_MEM_WAIT) begin
            ret_d = (state_q == ST_REDIRECT) ? ST_REDIRECT : ST_RUN;
         end
      end else if (ex_redirect_i && ex_valid_i) begin
         ifid_flush_o = 1'b1;
         idex_flush_o = 1'b1;
         redir_inc    = 1'b1;
         if (HAS_EXTRA) begin
            state_d = ST_REDIRECT;
            fcnt_d  = FLUSH_LOAD;
         end
      end else if (eff_st == ST_REDIRECT) begin
         ifid_flush_o = 1'b1;
         idex_flush_o = 1'b1;
         if (fcnt_q <= FCNT_W'(1)) begin
            fcnt_d = '0;
         end else begin
            fcnt_d  = fcnt_q - FCNT_W'(1);
            state_d = ST_REDIRECT;
         end
      end else if (load_use) begin
         pc_stall_o   = 1'b1;
         ifid_stall_o = 1'b1;
         idex_flush_o = 1'b1;
         ldu_inc      = 1'b1;
      end

      // Reset holds both front-end registers bubbled.
      if (!rst_ni) begin
         pc_stall_o    = 1'b0;
         ifid_stall_o  = 1'b0;
         idex_stall_o  = 1'b0;
         exmem_stall_o = 1'b0;
         ifid_flush_o  = 1'b1;
         idex_flush_o  = 1'b1;
      end
   end

   assign state_o = state_q;

   sat_counter #(.W(CNT_W)) u_ldu_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (cnt_clr_i),
      .inc_i  (ldu_inc),
      .cnt_o  (ldu_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_redir_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (cnt_clr_i),
      .inc_i  (redir_inc),
      .cnt_o  (redir_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_memw_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (cnt_clr_i),
      .inc_i  (memw_inc),
      .cnt_o  (memw_cnt_o)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: per-cycle expected outputs go through a scoreboard queue.
module tb_pipeline_ctrl;

   localparam int unsigned CW = 2;

   // Output vector order: pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall
   localparam logic [5:0] O_NONE = 6'b000000;
   localparam logic [5:0] O_LDU  = 6'b110010;
   localparam logic [5:0] O_FL   = 6'b001010;
   localparam logic [5:0] O_BUSY = 6'b110101;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       idv;
      logic       memrd;
      logic [4:0] rd;
      logic       exv;
      logic       redir;
      logic       busy;
      logic       clr;
      logic [7:0] exp;
   } stim_t;

   logic          clk, rst_n;
   logic [4:0]    rs1, rs2, rd;
   logic          idv, memrd, exv, redir, busy, clr;
   logic          pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall;
   logic [1:0]    state;
   logic [CW-1:0] ldu_cnt, redir_cnt, memw_cnt;

   int            checks = 0;
   int            errors = 0;
   logic [7:0]    sb_q[$];
   logic [7:0]    got, exp_v;
   stim_t         s[$];

   pipeline_ctrl #(.FLUSH_EXTRA(1), .CNT_W(CW)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .id_rs1_addr_i (rs1),
      .id_rs2_addr_i (rs2),
      .id_valid_i    (idv),
      .ex_memread_i  (memrd),
      .ex_rd_addr_i  (rd),
      .ex_valid_i    (exv),
      .ex_redirect_i (redir),
      .dmem_busy_i   (busy),
      .cnt_clr_i     (clr),
      .pc_stall_o    (pc_stall),
      .ifid_stall_o  (ifid_stall),
      .ifid_flush_o  (ifid_flush),
      .idex_stall_o  (idex_stall),
      .idex_flush_o  (idex_flush),
      .exmem_stall_o (exmem_stall),
      .state_o       (state),
      .ldu_cnt_o     (ldu_cnt),
      .redir_cnt_o   (redir_cnt),
      .memw_cnt_o    (memw_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic stim_t st(input logic [4:0] a1, input logic [4:0] a2, input logic iv,
                                input logic mr, input logic [4:0] d, input logic ev,
                                input logic rdr, input logic bz, input logic cl,
                                input logic [5:0] o, input logic [1:0] sv);
      stim_t r;
      r.rs1 = a1; r.rs2 = a2; r.idv = iv; r.memrd = mr; r.rd = d; r.exv = ev;
      r.redir = rdr; r.busy = bz; r.clr = cl; r.exp = {o, sv};
      return r;
   endfunction

   function automatic logic [7:0] outs();
      return {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, state};
   endfunction

   task automatic apply(input stim_t x);
      rs1 = x.rs1; rs2 = x.rs2; idv = x.idv; memrd = x.memrd; rd = x.rd;
      exv = x.exv; redir = x.redir; busy = x.busy; clr = x.clr;
      sb_q.push_back(x.exp);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 2'd0));
      void'(sb_q.pop_front());
      #3;
      checks++;
      if ({ifid_flush, idex_flush} !== 2'b11) begin
         errors++; $display("FAIL reset_flush: got %b expected 11", {ifid_flush, idex_flush});
      end
      checks++;
      if ({pc_stall, ifid_stall, idex_stall, exmem_stall, state} !== 6'b0) begin
         errors++; $display("FAIL reset_stall_state: got %b expected 000000",
                            {pc_stall, ifid_stall, idex_stall, exmem_stall, state});
      end
      checks++;
      if ({ldu_cnt, redir_cnt, memw_cnt} !== '0) begin
         errors++; $display("FAIL reset_cnt: got %b expected 0", {ldu_cnt, redir_cnt, memw_cnt});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_load_use();
      s = '{st(0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE, 2'd0),
            st(5, 0, 1, 1, 5, 1, 0, 0, 0, O_LDU,  2'd0),
            st(0, 0, 1, 0, 0, 0, 0, 0, 0, O_NONE, 2'd0),
            st(1, 5, 1, 1, 5, 1, 0, 0, 0, O_LDU,  2'd0),
            st(0, 0, 1, 0, 0, 0, 0, 0, 0, O_NONE, 2'd0),
            st(0, 0, 1, 1, 0, 1, 0, 0, 0, O_NONE, 2'd0),
            st(5, 0, 0, 1, 5, 1, 0, 0, 0, O_NONE, 2'd0),
            st(5, 0, 1, 0, 5, 1, 0, 0, 0, O_NONE, 2'd0),
            st(5, 6, 1, 1, 7, 1, 0, 0, 0, O_NONE, 2'd0),
            st(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 2'd0)};
      foreach (s[i]) begin
         @(posedge clk); #1; apply(s[i]);
         @(negedge clk); got = outs(); exp_v = sb_q.pop_front(); checks++;
         if (got !== exp_v) begin
            errors++; $display("FAIL load_use[%0d]: got %b expected %b", i, got, exp_v);
         end
      end
      @(posedge clk); #1; checks++;
      if (ldu_cnt !== 2'd2) begin
         errors++; $display("FAIL load_use_cnt: got %0d expected 2", ldu_cnt);
      end
   endtask

   task automatic test_redirect();
      s = '{st(0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE, 2'd0),
            st(0, 0, 0, 0, 0, 1, 1, 0, 0, O_FL,   2'd0),
            st(5, 0, 1, 1, 5, 1, 0, 0, 0, O_FL,   2'd1),
            st(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 2'd0),
            st(0, 0, 0, 0, 0, 0, 1, 0, 0, O_NONE, 2'd0)};
      foreach (s[i]) begin
         @(posedge clk); #1; apply(s[i]);
         @(negedge clk); got = outs(); exp_v = sb_q.pop_front(); checks++;
         if (got !== exp_v) begin
            errors++; $display("FAIL redirect[%0d]: got %b expected %b", i, got, exp_v);
         end
      end
      @(posedge clk); #1; checks++;
      if ({redir_cnt, ldu_cnt} !== {2'd1, 2'd0}) begin
         errors++; $display("FAIL redirect_cnt: got redir=%0d ldu=%0d expected 1 0", redir_cnt, ldu_cnt);
      end
   endtask

   task automatic test_mem_wait();
      s = '{st(0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE, 2'd0),
            st(0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY, 2'd0),
            st(0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY, 2'd2),
            st(0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY, 2'd2),
            st(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 2'd2),
            st(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 2'd0)};
      foreach (s[i]) begin
         @(posedge clk); #1; apply(s[i]);
         @(negedge clk); got = outs(); exp_v = sb_q.pop_front(); checks++;
         if (got !== exp_v) begin
            errors++; $display("FAIL mem_wait[%0d]: got %b expected %b", i, got, exp_v);
         end
      end
      @(posedge clk); #1; checks++;
      if (memw_cnt !== 2'd3) begin
         errors++; $display("FAIL mem_wait_cnt: got %0d expected 3", memw_cnt);
      end
   endtask

   task automatic test_busy_in_redirect();
      s = '{st(0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE, 2'd0),
            st(0, 0, 0, 0, 0, 1, 1, 0, 0, O_FL,   2'd0),
            st(0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY, 2'd1),
            st(0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY, 2'd2),
            st(0, 0, 0, 0, 0, 0, 0, 0, 0, O_FL,   2'd2),
            st(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 2'd0)};
      foreach (s[i]) begin
         @(posedge clk); #1; apply(s[i]);
         @(negedge clk); got = outs(); exp_v = sb_q.pop_front(); checks++;
         if (got !== exp_v) begin
            errors++; $display("FAIL busy_in_redirect[%0d]: got %b expected %b", i, got, exp_v);
         end
      end
      @(posedge clk); #1; checks++;
      if ({redir_cnt, memw_cnt} !== {2'd1, 2'd2}) begin
         errors++; $display("FAIL busy_in_redirect_cnt: got redir=%0d memw=%0d expected 1 2",
                            redir_cnt, memw_cnt);
      end
   endtask

   task automatic test_busy_and_redirect();
      s = '{st(0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE, 2'd0),
            st(0, 0, 0, 0, 0, 1, 1, 1, 0, O_BUSY, 2'd0),
            st(0, 0, 0, 0, 0, 1, 1, 0, 0, O_FL,   2'd2),
            st(0, 0, 0, 0, 0, 0, 0, 0, 0, O_FL,   2'd1),
            st(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 2'd0)};
      foreach (s[i]) begin
         @(posedge clk); #1; apply(s[i]);
         @(negedge clk); got = outs(); exp_v = sb_q.pop_front(); checks++;
         if (got !== exp_v) begin
            errors++; $display("FAIL busy_and_redirect[%0d]: got %b expected %b", i, got, exp_v);
         end
      end
      @(posedge clk); #1; checks++;
      if ({redir_cnt, memw_cnt} !== {2'd1, 2'd1}) begin
         errors++; $display("FAIL busy_and_redirect_cnt: got redir=%0d memw=%0d expected 1 1",
                            redir_cnt, memw_cnt);
      end
   endtask

   task automatic test_saturate();
      s = '{st(0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE, 2'd0),
            st(9, 0, 1, 1, 9, 1, 0, 0, 0, O_LDU,  2'd0),
            st(0, 9, 1, 1, 9, 1, 0, 0, 0, O_LDU,  2'd0),
            st(9, 9, 1, 1, 9, 1, 0, 0, 0, O_LDU,  2'd0),
            st(3, 9, 1, 1, 9, 1, 0, 0, 0, O_LDU,  2'd0),
            st(9, 3, 1, 1, 9, 1, 0, 0, 0, O_LDU,  2'd0),
            st(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 2'd0)};
      foreach (s[i]) begin
         @(posedge clk); #1; apply(s[i]);
         @(negedge clk); got = outs(); exp_v = sb_q.pop_front(); checks++;
         if (got !== exp_v) begin
            errors++; $display("FAIL saturate[%0d]: got %b expected %b", i, got, exp_v);
         end
      end
      @(posedge clk); #1; checks++;
      if (ldu_cnt !== 2'd3) begin
         errors++; $display("FAIL saturate_cnt: got %0d expected 3", ldu_cnt);
      end
      // Clear coincides with a hazard increment; the clear must win.
      s = '{st(9, 0, 1, 1, 9, 1, 0, 0, 1, O_LDU,  2'd0),
            st(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 2'd0)};
      foreach (s[i]) begin
         @(posedge clk); #1; apply(s[i]);
         @(negedge clk); got = outs(); exp_v = sb_q.pop_front(); checks++;
         if (got !== exp_v) begin
            errors++; $display("FAIL clear_vs_inc[%0d]: got %b expected %b", i, got, exp_v);
         end
      end
      @(posedge clk); #1; checks++;
      if (ldu_cnt !== 2'd0) begin
         errors++; $display("FAIL clear_vs_inc_cnt: got %0d expected 0", ldu_cnt);
      end
   endtask

   task automatic test_reset_mid_redirect();
      s = '{st(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 2'd0),
            st(0, 0, 0, 0, 0, 1, 1, 0, 0, O_FL,   2'd0)};
      foreach (s[i]) begin
         @(posedge clk); #1; apply(s[i]);
         @(negedge clk); got = outs(); exp_v = sb_q.pop_front(); checks++;
         if (got !== exp_v) begin
            errors++; $display("FAIL reset_mid_pre[%0d]: got %b expected %b", i, got, exp_v);
         end
      end
      @(posedge clk); #1;
      apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 2'd0));
      void'(sb_q.pop_front());
      checks++;
      if (state !== 2'd1) begin
         errors++; $display("FAIL reset_mid_in_redirect: got state %0d expected 1", state);
      end
      rst_n = 1'b0;
      #1; checks++;
      if ({pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, state} !==
          {O_FL, 2'd0}) begin
         errors++; $display("FAIL reset_mid_outputs: got %b expected %b", outs(), {O_FL, 2'd0});
      end
      checks++;
      if ({ldu_cnt, redir_cnt, memw_cnt} !== '0) begin
         errors++; $display("FAIL reset_mid_cnt: got %b expected 0", {ldu_cnt, redir_cnt, memw_cnt});
      end
      @(negedge clk);
      rst_n = 1'b1;
      s = '{st(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 2'd0),
            st(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 2'd0)};
      foreach (s[i]) begin
         @(posedge clk); #1; apply(s[i]);
         @(negedge clk); got = outs(); exp_v = sb_q.pop_front(); checks++;
         if (got !== exp_v) begin
            errors++; $display("FAIL reset_mid_post[%0d]: got %b expected %b", i, got, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_redirect();
      test_mem_wait();
      test_busy_in_redirect();
      test_busy_and_redirect();
      test_saturate();
      test_reset_mid_redirect();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
